// File: rtl/imem_arb_pkg.sv
// Purpose : shared types and constants for the instruction-memory access arbiter.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, transaction owner enum, bytes-per-word constant and
// a helper that selects one byte of a word in big-endian beat order.
package imem_arb_pkg;

    // Bytes per instruction word; the byte-wide memory is walked this many beats.
    localparam int BPW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        FETCH = 1'b0,
        LOAD  = 1'b1
    } owner_e;

    // Big-endian byte select: beat 0 carries word[31:24], beat 3 carries word[7:0].
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] beat);
        logic [7:0] b;
        case (beat)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/imem_access_arb_rr_arb2.sv
// Purpose : two-input round-robin arbiter (bit 0 = fetch, bit 1 = load).
// Latency : combinational grant; last-grant pointer updates on the clock edge of a grant.
// Backpressure: no grant while grant_en is low; a lone requester always wins.
//
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (pointer resets to LOAD)
//   req[1:0]    : request vector
//   grant_en    : arbitration window (arbiter owner is idle)
//   gnt[1:0]    : one-hot grant, zero when nothing is granted
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] gnt
);
    import imem_arb_pkg::*;

    owner_e last_q;
    owner_e last_d;

    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        if (grant_en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                // Tie: the requester that did not win last time goes now.
                2'b11:   gnt = (last_q == LOAD) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
            if (gnt[0]) begin
                last_d = FETCH;
            end else if (gnt[1]) begin
                last_d = LOAD;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= LOAD;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/imem_access_arb.sv
// Purpose : sequences the byte-wide instruction memory port between instruction fetch and a word loader.
// Latency : request seen in cycle 0, byte beats in cycles 1-4, ack/ready pulse in cycle 5.
// Backpressure: requesters hold req+addr(+data) until their one-cycle ack/ready; not re-sampled mid-transaction.
//
// Ports:
//   clk, reset                          : clock, asynchronous active-high reset
//   fetch_req/fetch_addr                : 32-bit instruction read request (byte address)
//   fetch_ack/fetch_instr/fetch_err     : completion pulse, assembled word (held), misalignment flag
//   ld_valid/ld_addr/ld_data            : 32-bit word write request
//   ld_ready/ld_err                     : completion pulse, misalignment flag
//   mem_addr/mem_we/mem_wdata/mem_rdata : byte port to the instruction memory (combinational read)
//
// Build option: define IMEM_ALIGN_CHK_EN to reject word accesses whose addr[1:0] != 0
// (one-cycle error completion, no memory access). Without it, misaligned and
// wrapping accesses are carried out byte by byte and the error outputs are tied 0.
module imem_access_arb #(
    parameter int AW  = 5,
    parameter int BPW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    output logic          fetch_ack,
    output logic [31:0]   fetch_instr,
    output logic          fetch_err,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    output logic          ld_ready,
    output logic          ld_err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);
    import imem_arb_pkg::*;

    localparam logic [1:0] LAST_BEAT = 2'(BPW - 1);

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic [AW-1:0] base_q,  base_d;
    logic [1:0]    beat_q,  beat_d;
    // Bytes collected from the first three beats; the final beat completes the word.
    logic [23:0]   shift_q, shift_d;
    // Architectural result register: only updated when a fetch completes.
    logic [31:0]   instr_q, instr_d;

    logic [1:0]    gnt;
    logic [AW-1:0] req_addr;
    logic          arb_en;

    assign arb_en   = (state_q == IDLE);
    assign req_addr = gnt[1] ? ld_addr : fetch_addr;

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .reset    (reset),
        .req      ({ld_valid, fetch_req}),
        .grant_en (arb_en),
        .gnt      (gnt)
    );

`ifdef IMEM_ALIGN_CHK_EN
    logic err_q, err_d;
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        base_d    = base_q;
        beat_d    = beat_q;
        shift_d   = shift_q;
        instr_d   = instr_q;
`ifdef IMEM_ALIGN_CHK_EN
        err_d     = err_q;
`endif
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
        fetch_ack = 1'b0;
        ld_ready  = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt != 2'b00) begin
                    owner_d = gnt[1] ? LOAD : FETCH;
                    base_d  = req_addr;
                    beat_d  = 2'd0;
                    state_d = BEAT;
`ifdef IMEM_ALIGN_CHK_EN
                    // Misaligned word: complete immediately with an error, touch no memory.
                    err_d = (req_addr[1:0] != 2'b00);
                    if (err_d) begin
                        state_d = DONE;
                        if (!gnt[1]) begin
                            instr_d = 32'h0;
                        end
                    end
`endif
                end
            end

            BEAT: begin
                // Address arithmetic is AW bits wide, so a word straddling the top wraps to 0.
                mem_addr = base_q + AW'(beat_q);
                if (owner_q == LOAD) begin
                    // Loader holds ld_data stable until ld_ready, so it is used live.
                    mem_we    = 1'b1;
                    mem_wdata = word_byte(ld_data, beat_q);
                end else if (beat_q == LAST_BEAT) begin
                    instr_d = {shift_q, mem_rdata};
                end else begin
                    shift_d = {shift_q[15:0], mem_rdata};
                end

                if (beat_q == LAST_BEAT) begin
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end

            DONE: begin
                fetch_ack = (owner_q == FETCH);
                ld_ready  = (owner_q == LOAD);
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef IMEM_ALIGN_CHK_EN
    assign fetch_err = fetch_ack & err_q;
    assign ld_err    = ld_ready & err_q;
`else
    assign fetch_err = 1'b0;
    assign ld_err    = 1'b0;
`endif

    assign fetch_instr = instr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= FETCH;
            base_q  <= '0;
            beat_q  <= 2'd0;
            shift_q <= 24'h0;
            instr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            base_q  <= base_d;
            beat_q  <= beat_d;
            shift_q <= shift_d;
            instr_q <= instr_d;
        end
    end

`ifdef IMEM_ALIGN_CHK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_imem_access_arb.sv
// Purpose : self-checking bench for imem_access_arb with a byte-array memory model.
// Latency : checks cycle-5 completion (cycle 1 for rejected misaligned words when IMEM_ALIGN_CHK_EN is defined).
// Backpressure: requests held until ack/ready, as a compliant requester would.
module tb_imem_access_arb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req = 1'b0;
    logic [4:0]  fetch_addr = '0;
    logic        fetch_ack;
    logic [31:0] fetch_instr;
    logic        fetch_err;
    logic        ld_valid = 1'b0;
    logic [4:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        ld_ready;
    logic        ld_err;
    logic [4:0]  mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

`ifdef IMEM_ALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int ready_cnt = 0;

    always #5 clk = ~clk;

    imem_access_arb #(.AW(5), .BPW(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ack   (fetch_ack),
        .fetch_instr (fetch_instr),
        .fetch_err   (fetch_err),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .ld_err      (ld_err),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Byte memory with a bench-side backdoor write port for preloading.
    logic [7:0] mem [32];
    logic       bk_we = 1'b0;
    logic [4:0] bk_addr = '0;
    logic [7:0] bk_data = '0;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (bk_we) mem[bk_addr] <= bk_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic poke(input logic [4:0] a, input logic [7:0] d);
        bk_we = 1'b1; bk_addr = a; bk_data = d;
        @(posedge clk); #1;
        bk_we = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit rejected(input logic [4:0] a);
        return CHK && (a[1:0] != 2'b00);
    endfunction

    // Scoreboard: one expected completion per issued transaction, in issue order.
    typedef struct {
        logic        is_load;
        logic [31:0] instr;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    always @(negedge clk) begin
        if (!reset && (fetch_ack || ld_ready)) begin
            if (ld_ready) ready_cnt++;
            if (sb_q.size() == 0) begin
                chk("unexpected_completion", {30'h0, fetch_ack, ld_ready}, 32'h0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("completion_kind", {30'h0, fetch_ack, ld_ready}, e.is_load ? 32'h1 : 32'h2);
                if (e.is_load) begin
                    chk("ld_err", {31'h0, ld_err}, {31'h0, e.err});
                end else begin
                    chk("fetch_instr", fetch_instr, e.instr);
                    chk("fetch_err", {31'h0, fetch_err}, {31'h0, e.err});
                end
            end
        end
    end

    // One transaction from an otherwise idle DUT; checks latency and per-beat port activity.
    task automatic run_txn(input logic is_load, input logic [4:0] addr, input logic [31:0] data,
                           input logic [31:0] exp_instr, input string tag);
        bit         rej;
        bit         we_seen;
        int         lat;
        logic [4:0] ea;
        logic [7:0] wb;
        exp_t       e;
        rej = rejected(addr);
        we_seen = 1'b0;
        lat = -1;
        e.is_load = is_load;
        e.instr   = rej ? 32'h0 : exp_instr;
        e.err     = rej;
        sb_q.push_back(e);
        if (is_load) begin
            ld_valid = 1'b1; ld_addr = addr; ld_data = data;
        end else begin
            fetch_req = 1'b1; fetch_addr = addr;
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_we) we_seen = 1'b1;
            if (!rej && c >= 1 && c <= 4) begin
                ea = addr + 5'(c - 1);
                wb = 8'(data >> (8 * (4 - c)));
                chk({tag, "_mem_addr"}, {27'h0, mem_addr}, {27'h0, ea});
                chk({tag, "_mem_we"}, {31'h0, mem_we}, {31'h0, is_load});
                if (is_load) chk({tag, "_mem_wdata"}, {24'h0, mem_wdata}, {24'h0, wb});
            end
            if ((is_load && ld_ready) || (!is_load && fetch_ack)) lat = c;
            @(posedge clk); #1;
            if (lat >= 0) break;
        end
        fetch_req = 1'b0;
        ld_valid = 1'b0;
        chk({tag, "_latency"}, lat, rej ? 32'd1 : 32'd5);
        if (!is_load || rej) chk({tag, "_no_write"}, {31'h0, we_seen}, 32'h0);
    endtask

    typedef struct {
        logic        is_load;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_nochk;
        logic [31:0] exp_chk;
    } vec_t;
    vec_t vecs[9];

    initial begin
        int fa1, fa2, lr, nf, rc0;
        bit drop_ld, drop_f;
        logic [31:0] last_exp;

        vecs[0] = '{1'b0, 5'd0,  32'h0,        32'h8C010000, 32'h8C010000};
        vecs[1] = '{1'b1, 5'd4,  32'h00201020, 32'h0,        32'h0};
        vecs[2] = '{1'b0, 5'd4,  32'h0,        32'h00201020, 32'h00201020};
        vecs[3] = '{1'b1, 5'd12, 32'hDEADBEEF, 32'h0,        32'h0};
        vecs[4] = '{1'b0, 5'd12, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
        vecs[5] = '{1'b0, 5'd30, 32'h0,        32'h5AC38C01, 32'h0};
        vecs[6] = '{1'b1, 5'd29, 32'hA1B2C3D4, 32'h0,        32'h0};
        vecs[7] = '{1'b0, 5'd28, 32'h0,        32'h00A1B2C3, 32'h00005AC3};
        vecs[8] = '{1'b0, 5'd0,  32'h0,        32'hD4010000, 32'h8C010000};

        // Preload memory while reset is held.
        for (int i = 0; i < 32; i++) poke(5'(i), 8'h00);
        poke(5'd0, 8'h8C); poke(5'd1, 8'h01);
        poke(5'd30, 8'h5A); poke(5'd31, 8'hC3);

        @(negedge clk);
        chk("rst_fetch_ack", {31'h0, fetch_ack}, 32'h0);
        chk("rst_ld_ready", {31'h0, ld_ready}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_addr", {27'h0, mem_addr}, 32'h0);
        chk("rst_fetch_instr", fetch_instr, 32'h0);
        chk("rst_errs", {30'h0, fetch_err, ld_err}, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Simultaneous requests right after reset; fetch keeps requesting after its ack,
        // so cycle 6 is a second tie that the load must win.
        sb_q.push_back('{1'b0, 32'h00000000, 1'b0});
        sb_q.push_back('{1'b1, 32'h0, 1'b0});
        sb_q.push_back('{1'b0, 32'h11223344, 1'b0});
        fetch_req = 1'b1; fetch_addr = 5'd16;
        ld_valid = 1'b1; ld_addr = 5'd16; ld_data = 32'h11223344;
        fa1 = -1; fa2 = -1; lr = -1; nf = 0;
        for (int c = 0; c < 40; c++) begin
            drop_ld = 1'b0; drop_f = 1'b0;
            @(negedge clk);
            if (fetch_ack) begin
                if (nf == 0) fa1 = c; else begin fa2 = c; drop_f = 1'b1; end
                nf++;
            end
            if (ld_ready) begin lr = c; drop_ld = 1'b1; end
            @(posedge clk); #1;
            if (drop_ld) ld_valid = 1'b0;
            if (drop_f) begin fetch_req = 1'b0; break; end
        end
        fetch_req = 1'b0; ld_valid = 1'b0;
        chk("tie_fetch_first_cycle", fa1, 32'd5);
        chk("tie_load_cycle", lr, 32'd11);
        chk("tie_fetch_second_cycle", fa2, 32'd17);

        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].is_load, vecs[i].addr, vecs[i].data,
                    CHK ? vecs[i].exp_chk : vecs[i].exp_nochk, $sformatf("vec%0d", i));
        end
        last_exp = CHK ? vecs[8].exp_chk : vecs[8].exp_nochk;
        repeat (3) @(posedge clk);
        #1;
        chk("instr_hold", fetch_instr, last_exp);
        chk("loaded_bytes_4_7", {mem[4], mem[5], mem[6], mem[7]}, 32'h00201020);

        // Reset during beat 2 of a load to address 8.
        rc0 = ready_cnt;
        ld_valid = 1'b1; ld_addr = 5'd8; ld_data = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid_mem_we", {31'h0, mem_we}, 32'h0);
        ld_valid = 1'b0;
        @(negedge clk); @(posedge clk); @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_bytes_8_11", {mem[8], mem[9], mem[10], mem[11]}, 32'hCAFE0000);
        chk("rst_mid_no_ready", ready_cnt - rc0, 32'h0);
        run_txn(1'b0, 5'd8, 32'h0, 32'hCAFE0000, "post_rst_fetch");

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", sb_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
